// File: rtl/fft_frame_ctrl_if.sv
// Link between fft_frame_ctrl and the fftmain core, plus the peak-result outputs.
// The master side is the frame controller; the slave side is the core/consumer.
interface fft_frame_ctrl_if #(
  parameter int WIDTH  = 12,
  parameter int LGSIZE = 10,
  parameter int MAG_W  = 2*WIDTH+2
);
  logic                    o_fft_ce;
  logic                    o_fft_reset;
  logic                    i_fft_sync;
  logic signed [WIDTH-1:0] i_fft_real;
  logic signed [WIDTH-1:0] i_fft_imag;
  logic                    o_peak_valid;
  logic [LGSIZE-1:0]       o_peak_bin;
  logic [MAG_W-1:0]        o_peak_mag;
  logic                    o_sync_err;

  modport master (
    output o_fft_ce, o_fft_reset, o_peak_valid, o_peak_bin, o_peak_mag, o_sync_err,
    input  i_fft_sync, i_fft_real, i_fft_imag
  );

  modport slave (
    input  o_fft_ce, o_fft_reset, o_peak_valid, o_peak_bin, o_peak_mag, o_sync_err,
    output i_fft_sync, i_fft_real, i_fft_imag
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer and peak detector for fftmain: gates ce, aligns to sync, reports peak bin.
// Define FFT_CTRL_HALF_SPECTRUM_EN to search only bins 0..N/2-1 (real-input spectrum).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | disarmed, core held in reset, ce gated off
// WAIT_SYNC | armed, beats ignored until one carries the core's sync (bin 0)
// CAPTURE   | each beat is one bin of the current frame
module fft_frame_ctrl #(
  parameter int WIDTH  = 12,
  parameter int LGSIZE = 10,
  parameter int MAG_W  = 2*WIDTH+2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_sample_valid,
  input  logic               i_arm,
  input  logic               i_continuous,
  output logic               o_busy,
  fft_frame_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    CAPTURE   = 2'd2
  } state_t;

`ifdef FFT_CTRL_HALF_SPECTRUM_EN
  localparam bit                HALF_SPECTRUM = 1'b1;
  localparam logic [LGSIZE-1:0] LAST_BIN      = {1'b0, {(LGSIZE-1){1'b1}}};
`else
  localparam bit                HALF_SPECTRUM = 1'b0;
  localparam logic [LGSIZE-1:0] LAST_BIN      = '1;
`endif

  state_t            state_q, state_d;
  logic [LGSIZE-1:0] cnt_q, cnt_d;
  logic              fft_reset_q, fft_reset_d;

  logic              beat;
  logic              proc;
  logic              last;
  logic              abort;
  logic [LGSIZE-1:0] proc_bin;
  logic [MAG_W-1:0]  re_x, im_x, mag;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q, s1_last_d;
  logic [LGSIZE-1:0] s1_bin_q, s1_bin_d;
  logic [MAG_W-1:0]  s1_mag_q, s1_mag_d;

  logic [LGSIZE-1:0] max_bin_q, max_bin_d;
  logic [MAG_W-1:0]  max_mag_q, max_mag_d;
  logic              peak_valid_q, peak_valid_d;
  logic [LGSIZE-1:0] peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0]  peak_mag_q, peak_mag_d;
  logic              sync_err_q, sync_err_d;

  assign beat = i_sample_valid & (state_q != IDLE);

  // Sign-extend first so the modular products equal the true squares in MAG_W bits.
  assign re_x = {{(MAG_W-WIDTH){bus.i_fft_real[WIDTH-1]}}, bus.i_fft_real};
  assign im_x = {{(MAG_W-WIDTH){bus.i_fft_imag[WIDTH-1]}}, bus.i_fft_imag};
  assign mag  = re_x * re_x + im_x * im_x;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    proc     = 1'b0;
    abort    = 1'b0;
    proc_bin = '0;
    last     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_arm) begin
          state_d = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        if (beat && bus.i_fft_sync) begin
          proc    = 1'b1;
          cnt_d   = LGSIZE'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (beat) begin
          proc = 1'b1;
          if (bus.i_fft_sync && (cnt_q != '0)) begin
            abort = 1'b1;
          end else begin
            proc_bin = cnt_q;
          end
          cnt_d = proc_bin + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    last = proc && (proc_bin == LAST_BIN);
    if (last) begin
      cnt_d = '0;
      if (!i_continuous) begin
        state_d = IDLE;
      end else if (HALF_SPECTRUM) begin
        state_d = WAIT_SYNC;
      end else begin
        state_d = CAPTURE;
      end
    end

    fft_reset_d = (state_d == IDLE);
  end

  // Stage 1: magnitude and bin tag of the processed beat.
  always_comb begin
    s1_valid_d = proc;
    s1_last_d  = last;
    s1_bin_d   = s1_bin_q;
    s1_mag_d   = s1_mag_q;
    sync_err_d = abort;
    if (proc) begin
      s1_bin_d = proc_bin;
      s1_mag_d = mag;
    end
  end

  // Stage 2: bin 0 reloads the max (this also discards an aborted frame); ties keep the lower bin.
  always_comb begin
    max_bin_d    = max_bin_q;
    max_mag_d    = max_mag_q;
    peak_valid_d = 1'b0;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    if (s1_valid_q) begin
      if ((s1_bin_q == '0) || (s1_mag_q > max_mag_q)) begin
        max_bin_d = s1_bin_q;
        max_mag_d = s1_mag_q;
      end
      if (s1_last_q) begin
        peak_valid_d = 1'b1;
        peak_bin_d   = max_bin_d;
        peak_mag_d   = max_mag_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fft_reset_q  <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_bin_q     <= '0;
      s1_mag_q     <= '0;
      max_bin_q    <= '0;
      max_mag_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fft_reset_q  <= fft_reset_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_bin_q     <= s1_bin_d;
      s1_mag_q     <= s1_mag_d;
      max_bin_q    <= max_bin_d;
      max_mag_q    <= max_mag_d;
      peak_valid_q <= peak_valid_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign o_busy           = (state_q != IDLE);
  assign bus.o_fft_ce     = beat;
  assign bus.o_fft_reset  = fft_reset_q;
  assign bus.o_peak_valid = peak_valid_q;
  assign bus.o_peak_bin   = peak_bin_q;
  assign bus.o_peak_mag   = peak_mag_q;
  assign bus.o_sync_err   = sync_err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with N=8; expected strobes are queued before stimulus.
module tb_fft_frame_ctrl;
  localparam int WIDTH  = 12;
  localparam int LGSIZE = 3;
  localparam int MAG_W  = 2*WIDTH+2;
  localparam int NV     = 20;

  typedef struct {
    int     bin;
    longint mag;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_sample_valid = 1'b0;
  logic i_arm = 1'b0;
  logic i_continuous = 1'b0;
  logic o_busy;

  fft_frame_ctrl_if #(.WIDTH(WIDTH), .LGSIZE(LGSIZE), .MAG_W(MAG_W)) bus ();

  fft_frame_ctrl #(.WIDTH(WIDTH), .LGSIZE(LGSIZE), .MAG_W(MAG_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_sample_valid (i_sample_valid),
    .i_arm          (i_arm),
    .i_continuous   (i_continuous),
    .o_busy         (o_busy),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   serr_q[$];

  int   vre[NV];
  int   vim[NV];
  logic vsync[NV];
  logic vcont[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of its queue, in value and in cycle.
  always @(negedge clk) begin
    exp_t e;
    int   c;
    if (bus.o_peak_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_peak_valid", 64'(bus.o_peak_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("peak_bin", 64'(bus.o_peak_bin), 64'(e.bin));
        chk("peak_mag", 64'(bus.o_peak_mag), 64'(e.mag));
        chk("peak_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (bus.o_sync_err !== 1'b0) begin
      if (serr_q.size() == 0) begin
        chk("unexpected_sync_err", 64'(bus.o_sync_err), 64'd0);
      end else begin
        c = serr_q.pop_front();
        chk("sync_err_cycle", 64'(cyc), 64'(c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge at which beat i of the next run() is sampled.
  function automatic int ed(input int i, input bit gaps);
    return cyc + 1 + (gaps ? 2*i : i);
  endfunction

  task automatic push_exp(input int bin, input longint mag, input int c);
    exp_t e;
    e.bin = bin;
    e.mag = mag;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic clear_vec(input logic cont);
    for (int i = 0; i < NV; i++) begin
      vre[i]   = 0;
      vim[i]   = 0;
      vsync[i] = 1'b0;
      vcont[i] = cont;
    end
  endtask

  task automatic run(input int n, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      i_sample_valid = 1'b1;
      i_continuous   = vcont[i];
      bus.i_fft_sync = vsync[i];
      t = vre[i];
      bus.i_fft_real = t[WIDTH-1:0];
      t = vim[i];
      bus.i_fft_imag = t[WIDTH-1:0];
      tick();
      if (gaps) begin
        i_sample_valid = 1'b0;
        bus.i_fft_sync = 1'b1;
        bus.i_fft_real = 12'sh7ff;
        bus.i_fft_imag = 12'sh7ff;
        tick();
      end
    end
    i_sample_valid = 1'b0;
    bus.i_fft_sync = 1'b0;
  endtask

  task automatic arm(input logic cont);
    i_arm        = 1'b1;
    i_continuous = cont;
    tick();
    i_arm = 1'b0;
    chk("arm_fft_reset", 64'(bus.o_fft_reset), 64'd0);
    chk("arm_busy", 64'(o_busy), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_fft_reset"}, 64'(bus.o_fft_reset), 64'd1);
  endtask

  initial begin
    bus.i_fft_sync = 1'b0;
    bus.i_fft_real = '0;
    bus.i_fft_imag = '0;
    clear_vec(1'b0);

    reset          = 1'b1;
    i_sample_valid = 1'b1;
    tick();
    tick();
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_peak_valid", 64'(bus.o_peak_valid), 64'd0);
    chk("rst_peak_bin", 64'(bus.o_peak_bin), 64'd0);
    chk("rst_peak_mag", 64'(bus.o_peak_mag), 64'd0);
    chk("rst_sync_err", 64'(bus.o_sync_err), 64'd0);
    chk("rst_fft_reset", 64'(bus.o_fft_reset), 64'd1);
    chk("rst_fft_ce", 64'(bus.o_fft_ce), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_fft_ce_gated", 64'(bus.o_fft_ce), 64'd0);
    i_sample_valid = 1'b0;
    tick();

`ifdef FFT_CTRL_HALF_SPECTRUM_EN
    // Half spectrum: frame1 peak at bin 3 (bin 6 ignored), frame2 bin 1, frame3 bin 2.
    clear_vec(1'b1);
    vsync[0] = 1'b1; vre[3] = 10; vre[6] = 1000;
    vsync[8] = 1'b1; vre[9] = 7; vre[12] = 500; vre[13] = 500;
    vsync[14] = 1'b1; vim[16] = -20; vcont[17] = 1'b0;
    arm(1'b1);
    push_exp(3, 100, ed(3, 0) + 1);
    push_exp(1, 49, ed(11, 0) + 1);
    push_exp(2, 400, ed(17, 0) + 1);
    run(18, 0);
    check_idle("half_end");
    repeat (4) tick();
`else
    // 1: single shot, worst-case magnitude at bin 5.
    clear_vec(1'b0);
    for (int i = 0; i < 8; i++) vre[i] = 1;
    vre[5] = -2048; vim[5] = -2048; vsync[0] = 1'b1;
    arm(1'b0);
    push_exp(5, 8388608, ed(7, 0) + 1);
    run(8, 0);
    check_idle("t1_end");
    i_sample_valid = 1'b1;
    #1;
    chk("t1_ce_after_frame", 64'(bus.o_fft_ce), 64'd0);
    i_sample_valid = 1'b0;
    repeat (4) tick();

    // 2: two pre-sync beats ignored; tie between bins 2 and 6 keeps bin 2.
    clear_vec(1'b0);
    vre[0] = 2000; vre[1] = 2000;
    vsync[2] = 1'b1; vre[4] = 50; vre[8] = 50;
    arm(1'b0);
    push_exp(2, 2500, ed(9, 0) + 1);
    run(10, 0);
    check_idle("t2_end");
    repeat (4) tick();

    // 3: continuous, valid toggling with junk+sync in the gaps; continuous dropped in frame 2.
    clear_vec(1'b1);
    for (int i = 0; i < 8; i++) begin
      vre[i] = i; vim[i] = i;
      vre[8+i] = 1; vim[8+i] = 1;
    end
    vre[3] = -300; vim[3] = 400;
    vre[14] = 0; vim[14] = -700;
    vsync[0] = 1'b1; vsync[8] = 1'b1;
    for (int i = 12; i < 16; i++) vcont[i] = 1'b0;
    arm(1'b1);
    push_exp(3, 250000, ed(7, 1) + 1);
    push_exp(6, 490000, ed(15, 1) + 1);
    run(16, 1);
    check_idle("t3_end");
    repeat (4) tick();

    // 4: re-sync at bin 4 aborts the frame holding a large bin 1.
    clear_vec(1'b0);
    vsync[0] = 1'b1; vre[0] = 3;
    vre[1] = 2047; vim[1] = 2047;
    vre[2] = 1; vre[3] = 1;
    vsync[4] = 1'b1; vre[4] = 5;
    for (int i = 5; i < 12; i++) vre[i] = 2;
    vre[7] = 0; vim[7] = 30;
    arm(1'b0);
    serr_q.push_back(ed(4, 0));
    push_exp(3, 900, ed(11, 0) + 1);
    run(12, 0);
    check_idle("t4_end");
    repeat (4) tick();

    // 5: reset on the bin 3 beat; nothing may be reported afterwards.
    clear_vec(1'b0);
    vsync[0] = 1'b1; vre[1] = 2047; vre[2] = 1;
    arm(1'b0);
    run(3, 0);
    reset          = 1'b1;
    i_sample_valid = 1'b1;
    bus.i_fft_real = 12'sd100;
    tick();
    chk("t5_busy", 64'(o_busy), 64'd0);
    chk("t5_peak_valid", 64'(bus.o_peak_valid), 64'd0);
    chk("t5_peak_bin", 64'(bus.o_peak_bin), 64'd0);
    chk("t5_peak_mag", 64'(bus.o_peak_mag), 64'd0);
    chk("t5_sync_err", 64'(bus.o_sync_err), 64'd0);
    chk("t5_fft_reset", 64'(bus.o_fft_reset), 64'd1);
    chk("t5_fft_ce", 64'(bus.o_fft_ce), 64'd0);
    reset          = 1'b0;
    i_sample_valid = 1'b0;
    repeat (8) tick();
`endif

    chk("peak_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("sync_err_queue_drained", 64'(serr_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer and peak detector for the streaming `fftmain` core. It gates the core's clock enable from an upstream sample-valid strobe and holds the core in reset while disarmed. It aligns to the core's frame sync, computes per-bin magnitude and reports the peak bin and magnitude of each captured frame. It sits between the ADC sample stream and the top-level consumer, replacing the free-running `ce` tie-off.

## Interface

Parameters:
- `WIDTH`, 12: signed width of each FFT output component.
- `LGSIZE`, 10: log2 of FFT length N.
- `MAG_W`, 2*WIDTH+2: magnitude width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `i_sample_valid` in 1: upstream sample strobe.
- `i_arm` in 1: start request; sampled only in IDLE.
- `i_continuous` in 1: repeat frames; sampled at end of each frame.
- `o_fft_ce` out 1: clock enable to `fftmain`.
- `o_fft_reset` out 1: reset to `fftmain`.
- `i_fft_sync` in 1: `fftmain` sync; marks bin 0 when coincident with `o_fft_ce`.
- `i_fft_real`, `i_fft_imag` in WIDTH each, signed: `fftmain` result.
- `o_busy` out 1: state != IDLE.
- `o_peak_valid` out 1: one-cycle result strobe.
- `o_peak_bin` out LGSIZE: index of peak bin.
- `o_peak_mag` out MAG_W: re²+im² of peak bin.
- `o_sync_err` out 1: one-cycle pulse, sync seen mid-frame.

## Operation

- States: IDLE, WAIT_SYNC, CAPTURE.
- IDLE: `o_fft_ce`=0, `o_fft_reset`=1. `i_arm`=1 -> WAIT_SYNC.
- `o_fft_ce` = `i_sample_valid` & (state != IDLE), combinational. `o_fft_reset` = (state == IDLE), registered with the state.
- "Beat" = cycle with `o_fft_ce`=1. Result inputs are meaningful only on beats.
- WAIT_SYNC: a beat with `i_fft_sync` is bin 0; it is processed and the block enters CAPTURE with bin counter = 1. Beats without sync are ignored.
- CAPTURE: each beat is processed as bin = counter; the counter increments.
  - A beat with sync and counter != 0 aborts the frame: pulse `o_sync_err`, discard the running max, treat the beat as bin 0, stay in CAPTURE.
  - A beat with sync and counter = 0 (wrapped) is a normal bin 0.
- Last searched bin L = N-1. After L is processed:
  - `i_continuous`=1 -> stay in CAPTURE (full spectrum) or go to WAIT_SYNC (see Configuration).
  - `i_continuous`=0 -> IDLE.
- Magnitude: sign-extended re*re + im*im, exact in MAG_W. Worst case is -2^(WIDTH-1) on both components.
- Peak search:
  - Bin 0 loads the running max unconditionally.
  - Later bins replace the max only on strictly greater magnitude, so ties keep the lowest bin.
- `i_arm` outside IDLE is ignored. `i_sample_valid` low stalls everything with no state change.

## Timing

- Stage 1: registers mag, bin index and last-flag on a beat.
- Stage 2: registers the compare/update of the running max.
- `o_peak_valid` pulses exactly 2 cycles after the beat carrying bin L, independent of later `i_sample_valid` activity. `o_peak_bin`/`o_peak_mag` update in the same cycle and hold until the next strobe.
- `o_sync_err` pulses 1 cycle after the offending beat.
- The aborted frame never produces `o_peak_valid`.
- Leaving IDLE: `o_fft_reset` deasserts the cycle after `i_arm`.
- Returning to IDLE: the pipeline still drains, so the final `o_peak_valid` is still issued.
- `reset`: next cycle state=IDLE and the pipeline is flushed. Reset values: `o_busy`=0, `o_peak_valid`=0, `o_peak_bin`=0, `o_peak_mag`=0, `o_sync_err`=0, `o_fft_reset`=1. `o_fft_ce` follows IDLE, so it is 0.
- Reset mid-frame drops the pending result; no strobe is issued.

## Configuration

- `FFT_CTRL_HALF_SPECTRUM_EN` defined:
  - L = N/2-1, since input is real and the upper half is a mirror.
  - After L: continuous -> WAIT_SYNC; bins N/2..N-1 are ignored.
  - A sync during those ignored bins is a normal frame start, not an error.
- Undefined: L = N-1; continuous stays in CAPTURE, expecting sync on the next beat.

## Test plan

All scenarios use LGSIZE=3 (N=8), WIDTH=12, and the bench driving the `i_fft_*` inputs directly.

1. Arm single-shot; sync on first beat. Bin 5 = (-2048, -2048), others = (1, 0) -> one `o_peak_valid` 2 cycles after bin 7 with bin=5, mag=8388608. Then IDLE, `o_fft_reset`=1.
2. Bins 2 and 6 both (50, 0), rest 0 -> bin=2, mag=2500.
3. Continuous, 16 consecutive beats (sync at 0 and 8), `i_sample_valid` toggling 1-0 -> two strobes. Drop `i_continuous` during the second frame -> IDLE after it.
4. Sync injected at bin 4 -> `o_sync_err` pulse, no strobe for the aborted frame. The next strobe covers the 8 beats starting at the re-sync.
5. `reset` asserted at bin 3 of CAPTURE -> next cycle all outputs at reset values; no strobe ever appears.
6. With the macro: bin 6 = (1000, 0), bin 3 = (10, 0) -> strobe 2 cycles after bin 3 with bin=3, mag=100. Ignored bins cause no error; the next sync restarts capture.
